// File: rtl/ps_morph3x3.sv
// Purpose: FWFT FIFO, head driven straight from storage.
// Latency: write visible at head the cycle after the push edge.
// Backpressure: push while full is accepted only with a same-cycle pop.
module sync_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_full,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign wr_full = (count == (AW+1)'(DEPTH));
  assign rd_vld  = (count != '0);
  assign do_rd   = rd_vld && rd_rdy;
  assign do_wr   = wr_vld && (!wr_full || do_rd);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

// Purpose: 3x3 binary morphology (pass/erode/dilate/majority) with sof/eol tagging.
// Latency: window at cycle N is at the FIFO head in cycle N+2.
// Backpressure: none upstream; results dropped when FIFO full, flagged by sticky o_overflow.
module ps_morph3x3 #(
  parameter int LINE_LENGTH = 640,
  parameter int LINE_COUNT  = 480,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [1:0] i_mode,
  input  logic [2:0] i_r0_data,
  input  logic [2:0] i_r1_data,
  input  logic [2:0] i_r2_data,
  input  logic       i_valid,
  output logic       o_data,
  output logic       o_sof,
  output logic       o_eol,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_overflow,
  input  logic       i_clear_ovf
);
  localparam int XW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int YW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [1:0]    r_mode;
  logic [1:0]    mode_eff;
  logic [8:0]    win;
  logic [3:0]    win_cnt;
  logic          at_sof;
  logic          at_eol;

  logic [8:0]    s1_win;
  logic [3:0]    s1_cnt;
  logic          s1_sof;
  logic          s1_eol;
  logic [1:0]    s1_mode;
  logic          s1_vld;
  logic          res;

  logic          fifo_full;
  logic [2:0]    head;
  logic          pop;
  logic          drop;

  assign win      = {i_r2_data, i_r1_data, i_r0_data};
  assign at_sof   = (x_cnt == '0) && (y_cnt == '0);
  assign at_eol   = (x_cnt == XW'(LINE_LENGTH - 1));
  // The frame-start window already uses the newly presented mode.
  assign mode_eff = (i_valid && at_sof) ? i_mode : r_mode;

  always_comb begin
    win_cnt = '0;
    for (int i = 0; i < 9; i++) win_cnt = win_cnt + {3'b000, win[i]};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      r_mode <= 2'b00;
    end else if (i_valid) begin
      if (at_sof) r_mode <= i_mode;
      if (at_eol) begin
        x_cnt <= '0;
        if (y_cnt == YW'(LINE_COUNT - 1)) y_cnt <= '0;
        else                              y_cnt <= y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_win  <= '0;
      s1_cnt  <= '0;
      s1_sof  <= 1'b0;
      s1_eol  <= 1'b0;
      s1_mode <= 2'b00;
      s1_vld  <= 1'b0;
    end else begin
      s1_win  <= win;
      s1_cnt  <= win_cnt;
      s1_sof  <= at_sof;
      s1_eol  <= at_eol;
      s1_mode <= mode_eff;
      s1_vld  <= i_valid;
    end
  end

  always_comb begin
    res = 1'b0;
    case (s1_mode)
      2'b00:   res = s1_win[4];
      2'b01:   res = (s1_cnt == 4'd9);
      2'b10:   res = (s1_cnt != 4'd0);
      default: res = (s1_cnt >= 4'd5);
    endcase
  end

  assign pop  = o_valid && i_ready;
  assign drop = s1_vld && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .wr_vld  (s1_vld),
    .wr_dat  ({s1_eol, s1_sof, res}),
    .wr_full (fifo_full),
    .rd_vld  (o_valid),
    .rd_rdy  (i_ready),
    .rd_dat  (head)
  );

  assign o_data = o_valid & head[0];
  assign o_sof  = o_valid & head[1];
  assign o_eol  = o_valid & head[2];

  // A drop in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)          o_overflow <= 1'b0;
    else if (drop)        o_overflow <= 1'b1;
    else if (i_clear_ovf) o_overflow <= 1'b0;
  end
endmodule

// File: tb/tb_ps_morph3x3.sv
// Bench for ps_morph3x3 at 4x3 frames with a 4-deep FIFO: vector table plus scoreboard.
module tb_ps_morph3x3;
  localparam int LL = 4;
  localparam int LC = 3;

  logic       i_clk;
  logic       i_rstn;
  logic [1:0] i_mode;
  logic [2:0] i_r0_data;
  logic [2:0] i_r1_data;
  logic [2:0] i_r2_data;
  logic       i_valid;
  logic       o_data;
  logic       o_sof;
  logic       o_eol;
  logic       o_valid;
  logic       i_ready;
  logic       o_overflow;
  logic       i_clear_ovf;

  ps_morph3x3 #(
    .LINE_LENGTH (LL),
    .LINE_COUNT  (LC),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_mode      (i_mode),
    .i_r0_data   (i_r0_data),
    .i_r1_data   (i_r1_data),
    .i_r2_data   (i_r2_data),
    .i_valid     (i_valid),
    .o_data      (o_data),
    .o_sof       (o_sof),
    .o_eol       (o_eol),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_overflow  (o_overflow),
    .i_clear_ovf (i_clear_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0] mode;
    logic [8:0] win;
    logic       exp;
  } vec_t;

  vec_t       vt [17];
  logic [2:0] exp_q [$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_popped = 0;
  int         bx = 0;
  int         by = 0;
  int         base;
  bit         pad_tog = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // Expected entries are {eol, sof, data}; tags come from the bench's own x/y count.
  task automatic send(input logic [1:0] m, input logic [8:0] w, input logic e, input bit keep);
    @(posedge i_clk); #1;
    i_mode = m;
    {i_r2_data, i_r1_data, i_r0_data} = w;
    i_valid = 1'b1;
    if (keep) exp_q.push_back({(bx == LL - 1), (bx == 0 && by == 0), e});
    if (bx == LL - 1) begin
      bx = 0;
      by = (by == LC - 1) ? 0 : by + 1;
    end else begin
      bx = bx + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
      i_valid = 1'b0;
    end
  endtask

  // All-ones and all-zeros windows give the same result in every mode.
  task automatic pad_to_frame();
    while (!(bx == 0 && by == 0)) begin
      pad_tog = ~pad_tog;
      send(2'b00, pad_tog ? 9'h1FF : 9'h000, pad_tog, 1'b1);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rstn && o_valid && i_ready) begin
      n_popped++;
      if (exp_q.size() == 0) check("unexpected_output", 1, 0);
      else check($sformatf("out%0d_eol_sof_data", n_popped), {o_eol, o_sof, o_data}, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // frame A remainder: erode latched; mode switch at x=2,y=1 ignored
    vt[0]  = '{2'b01, 9'h1FF, 1'b1};
    vt[1]  = '{2'b01, 9'h1EF, 1'b0};
    vt[2]  = '{2'b01, 9'h1FF, 1'b1};
    vt[3]  = '{2'b10, 9'h100, 1'b0};
    vt[4]  = '{2'b10, 9'h001, 1'b0};
    vt[5]  = '{2'b10, 9'h1FF, 1'b1};
    vt[6]  = '{2'b10, 9'h010, 1'b0};
    vt[7]  = '{2'b10, 9'h1FF, 1'b1};
    vt[8]  = '{2'b10, 9'h000, 1'b0};
    // frame B: dilate starts at sof
    vt[9]  = '{2'b10, 9'h100, 1'b1};
    vt[10] = '{2'b10, 9'h000, 1'b0};
    vt[11] = '{2'b11, 9'h00F, 1'b1};
    vt[12] = '{2'b10, 9'h010, 1'b1};
    // frame C: majority
    vt[13] = '{2'b11, 9'h01F, 1'b1};
    vt[14] = '{2'b11, 9'h00F, 1'b0};
    vt[15] = '{2'b11, 9'h1F0, 1'b1};
    vt[16] = '{2'b00, 9'h0E0, 1'b0};

    i_rstn = 1'b0;
    i_mode = 2'b00;
    i_r0_data = '0;
    i_r1_data = '0;
    i_r2_data = '0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_clear_ovf = 1'b0;
    #3;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_overflow", o_overflow, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_sof", o_sof, 0);
    check("rst_o_eol", o_eol, 0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    idle(2);

    // Erode with latency check: first o_valid two cycles after first window.
    send(2'b01, 9'h1FF, 1'b1, 1'b1);
    @(negedge i_clk); check("lat_cycle0_o_valid", o_valid, 0);
    send(2'b01, 9'h1FE, 1'b0, 1'b1);
    @(negedge i_clk); check("lat_cycle1_o_valid", o_valid, 0);
    send(2'b01, 9'h000, 1'b0, 1'b1);
    @(negedge i_clk); check("lat_cycle2_o_valid", o_valid, 1);

    for (int i = 0; i < 13; i++) send(vt[i].mode, vt[i].win, vt[i].exp, 1'b1);
    pad_to_frame();
    for (int i = 13; i < 17; i++) send(vt[i].mode, vt[i].win, vt[i].exp, 1'b1);
    pad_to_frame();
    idle(6);
    check("stream_queue_empty", exp_q.size(), 0);

    // Overrun with i_ready low: 4 held, 5th and 6th dropped.
    i_ready = 1'b0;
    send(2'b00, 9'h010, 1'b1, 1'b1);
    send(2'b00, 9'h000, 1'b0, 1'b1);
    send(2'b00, 9'h1EF, 1'b0, 1'b1);
    send(2'b00, 9'h010, 1'b1, 1'b1);
    send(2'b00, 9'h010, 1'b1, 1'b0);
    send(2'b00, 9'h000, 1'b0, 1'b0);
    @(negedge i_clk);
    check("ovf_before_drop", o_overflow, 0);
    check("full_o_valid", o_valid, 1);
    idle(1);
    @(negedge i_clk); check("ovf_after_drop", o_overflow, 1);
    idle(1);
    base = n_popped;
    i_ready = 1'b1;
    idle(8);
    check("drain1_count", n_popped - base, 4);
    check("drain1_empty", o_valid, 0);
    check("ovf_sticky", o_overflow, 1);
    @(posedge i_clk); #1; i_clear_ovf = 1'b1;
    @(posedge i_clk); #1; i_clear_ovf = 1'b0;
    @(negedge i_clk); check("ovf_cleared", o_overflow, 0);

    // Overrun again with clear held through the drop: drop wins.
    i_ready = 1'b0;
    i_clear_ovf = 1'b1;
    send(2'b00, 9'h010, 1'b1, 1'b1);
    send(2'b00, 9'h000, 1'b0, 1'b1);
    send(2'b00, 9'h010, 1'b1, 1'b1);
    send(2'b00, 9'h000, 1'b0, 1'b1);
    send(2'b00, 9'h010, 1'b1, 1'b0);
    idle(1);
    @(posedge i_clk); #1; i_clear_ovf = 1'b0;
    @(negedge i_clk); check("ovf_drop_beats_clear", o_overflow, 1);
    base = n_popped;
    i_ready = 1'b1;
    idle(8);
    check("drain2_count", n_popped - base, 4);

    // Asynchronous reset with 3 entries queued and overflow set.
    i_ready = 1'b0;
    send(2'b00, 9'h010, 1'b1, 1'b1);
    send(2'b00, 9'h010, 1'b1, 1'b1);
    send(2'b00, 9'h010, 1'b1, 1'b1);
    idle(4);
    @(negedge i_clk);
    check("pre_rst_o_valid", o_valid, 1);
    check("pre_rst_o_overflow", o_overflow, 1);
    #2;
    i_rstn = 1'b0;
    #1;
    check("async_rst_o_valid", o_valid, 0);
    check("async_rst_o_overflow", o_overflow, 0);
    check("async_rst_o_data", o_data, 0);
    check("async_rst_o_sof", o_sof, 0);
    check("async_rst_o_eol", o_eol, 0);
    exp_q.delete();
    bx = 0;
    by = 0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    i_ready = 1'b1;
    base = n_popped;
    send(2'b00, 9'h010, 1'b1, 1'b1);
    send(2'b00, 9'h1EF, 1'b0, 1'b1);
    idle(6);
    check("post_rst_count", n_popped - base, 2);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ps_morph3x3.md
Name: ps_morph3x3

Overview:
- Consumes the 3x3 binary window stream from the line-buffer kernel controller (three 3-bit rows plus a valid strobe).
- Applies a mode-selected 3x3 binary morphology operator: pass, erode, dilate or majority.
- Pushes the result pixel, with start-of-frame and end-of-line tags, into a small first-word-fall-through output FIFO with ready/valid backpressure toward the blob/labeling stage.
- The upstream stage cannot stall, so FIFO overrun is flagged rather than back-propagated.

Parameters:
- LINE_LENGTH, 640, pixels (windows) per line; sets the x counter wrap.
- LINE_COUNT, 480, lines per frame; sets the y counter wrap.
- FIFO_DEPTH, 16, output FIFO entries; must be a power of 2 and >= 2.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_mode  in  2  operator select: 00 pass centre, 01 erode (AND of 9), 10 dilate (OR of 9), 11 majority (popcount >= 5).
- i_r0_data  in  3  window top row; bit 0 = left, bit 1 = centre, bit 2 = right.
- i_r1_data  in  3  window middle row; i_r1_data[1] is the centre pixel.
- i_r2_data  in  3  window bottom row.
- i_valid  in  1  window valid; one window per cycle; never stalled.
- o_data  out  1  result pixel at FIFO head.
- o_sof  out  1  head pixel is x=0, y=0.
- o_eol  out  1  head pixel is x=LINE_LENGTH-1.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  downstream accepts the head this cycle.
- o_overflow  out  1  sticky; a result was dropped because the FIFO was full.
- i_clear_ovf  in  1  clears o_overflow.

Behaviour:
- Reset (async assert, sync release) clears:
  - all outputs to 0;
  - FIFO empty (read/write pointers and count 0);
  - x and y counters 0;
  - pipeline valids 0;
  - latched mode r_mode = 00.
- Reset mid-frame discards all in-flight and queued pixels. The next accepted window is treated as x=0, y=0.
- Counters advance once per i_valid:
  - x wraps at LINE_LENGTH-1 to 0;
  - y increments on each x wrap and wraps at LINE_COUNT-1 to 0.
  - Counters advance even when the result is later dropped, so framing stays aligned.
- Mode latch: r_mode <= i_mode only on an i_valid cycle with x=0 and y=0. That window and the rest of the frame use the new value. Mode changes at any other time are ignored until the next frame start.
- Stage 1 (cycle after i_valid) registers:
  - the 9-bit window;
  - a 4-bit popcount (0..9);
  - sof and eol tags;
  - the effective mode;
  - valid.
- Stage 2 (next cycle) computes the result from stage-1 registers:
  - erode = (popcount == 9);
  - dilate = (popcount != 0);
  - majority = (popcount >= 5);
  - pass = centre bit.
  - The result and tags are written into the FIFO as a 3-bit entry {eol, sof, data}.
- Latency: a window on i_valid at cycle N produces a FIFO write at the N+2 edge. With the FIFO empty, o_valid/o_data/o_sof/o_eol are visible in cycle N+2 (FWFT, head driven from storage).
- Throughput: 1 pixel/cycle sustained when i_ready stays high.
- Pop occurs when o_valid && i_ready. The head advances at the clock edge. o_data/o_sof/o_eol are don't-care when o_valid=0 and are driven 0 then.
- Push with the FIFO full:
  - with a pop in the same cycle: accepted, count unchanged;
  - without a pop: the entry is dropped and o_overflow <= 1.
- Simultaneous push and pop when not full: count unchanged and ordering preserved.
- Pop on empty is impossible (o_valid=0).
- o_overflow is sticky. i_clear_ovf=1 clears it, except that a drop in the same cycle wins and it stays 1.
- Pointer arithmetic is modulo FIFO_DEPTH. The count register is clog2(FIFO_DEPTH)+1 bits wide.

Test Plan:
- Reset behaviour: assert i_rstn=0 mid-stream with 3 entries queued. Required: o_valid=0, o_overflow=0 and all outputs 0 immediately, without waiting for a clock edge. After release, the first window is tagged o_sof=1.
- Erode: LINE_LENGTH=4, LINE_COUNT=3, mode 01 latched at frame start, i_ready=1. Send windows all-ones (9'h1FF), then 9'h1FE, then 9'h000. Required o_data sequence: 1, 0, 0. First o_valid occurs 2 cycles after the first i_valid.
- Majority and dilate:
  - Mode 11: popcount 5 window 9'h01F gives 1; popcount 4 window 9'h00F gives 0.
  - Next frame, mode 10: 9'h100 gives 1; 9'h000 gives 0.
- Mode latch: switch i_mode from 01 to 10 at pixel x=2, y=1. Required: the remainder of the frame is still eroded; dilation starts at the next sof window.
- Framing: stream 13 windows at 4x3 with i_ready=1. Required: o_eol=1 on outputs 4, 8 and 12; o_sof=1 on outputs 1 and 13; all other tags 0.
- Backpressure/overflow: FIFO_DEPTH=4, i_ready=0, send 6 windows. Required: o_overflow=1 from the 5th push, with 4 entries held.
  - Then raise i_ready: the first 4 results drain in order, the first with o_sof=1.
  - Pulse i_clear_ovf: o_overflow returns to 0.
  - Repeat the overrun with i_clear_ovf=1 held during the drop: o_overflow stays 1.
